scan_count_gen: RTL and testbench

Counter-generator partner for the `fsm` scan controller. `fsm` consumes `count_data`, `count_line` and `count_wind` and reports its phase on `state`. This block takes that `state` back and owns the three counters. It also presents a valid/ready read-address stream (`{wind, line, data}`) to the downstream buffer, and signals completion of a full scan.

---
 rtl/scan_pkg.sv | 21 ++
 rtl/wrap_counter.sv | 23 ++
 rtl/scan_count_gen.sv | 99 +++++++++
 tb/tb_scan_count_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared encodings and default widths for the scan controller (fsm) and its
// counter generator.
package scan_pkg;

  localparam int DW = 6;
  localparam int LW = 4;
  localparam int WW = 2;

  typedef enum logic [1:0] {
    S0    = 2'b00,
    S1    = 2'b01,
    S2    = 2'b10,
    S_ILL = 2'b11
  } phase_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrl_e;

endpackage

// File: rtl/wrap_counter.sv
// Free-running modulo-2^WIDTH counter with synchronous clear (clear beats
// increment) and synchronous active-low reset.
module wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/scan_count_gen.sv
// Counter generator for the fsm scan controller: owns the data/line/window
// counters, drives the read-address stream and flags scan completion.
module scan_count_gen
  import scan_pkg::*;
#(
  parameter int  DW = scan_pkg::DW,
  parameter int  LW = scan_pkg::LW,
  parameter int  WW = scan_pkg::WW,
  localparam int AW = DW + LW + WW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    state,
  input  logic          ready,
  output logic [DW-1:0] count_data,
  output logic [LW-1:0] count_line,
  output logic [WW-1:0] count_wind,
  output logic [AW-1:0] addr,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic          err
);

  ctrl_e ctrl;
  logic  run;
  logic  in_s0, in_s1, in_s2, in_ill;
  logic  transfer;
  logic  launch;
  logic  finish;

  always_comb begin
    in_s0  = 1'b0;
    in_s1  = 1'b0;
    in_s2  = 1'b0;
    in_ill = 1'b0;
    case (state)
      S0:      in_s0  = 1'b1;
      S1:      in_s1  = 1'b1;
      S2:      in_s2  = 1'b1;
      default: in_ill = 1'b1;
    endcase
  end

  assign run      = (ctrl == RUN);
  assign busy     = run;
  assign valid    = run && in_s0;
  assign transfer = valid && ready;
  assign launch   = !run && start;
  // The last window step both wraps count_wind and ends the scan.
  assign finish   = run && in_s2 && (count_wind == '1);
  assign addr     = {count_wind, count_line, count_data};

  wrap_counter #(.WIDTH(DW)) u_data (
    .clk   (clk),
    .reset (reset),
    .clr   (launch),
    .inc   (transfer),
    .count (count_data)
  );

  wrap_counter #(.WIDTH(LW)) u_line (
    .clk   (clk),
    .reset (reset),
    .clr   (launch || (run && in_s2)),
    .inc   (run && in_s1),
    .count (count_line)
  );

  wrap_counter #(.WIDTH(WW)) u_wind (
    .clk   (clk),
    .reset (reset),
    .clr   (launch || (run && in_s1)),
    .inc   (run && in_s2),
    .count (count_wind)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl <= IDLE;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= finish;
      if (run && in_ill) begin
        err <= 1'b1;
      end
      if (ctrl == IDLE) begin
        if (start) begin
          ctrl <= RUN;
        end
      end else if (finish) begin
        ctrl <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_scan_count_gen.sv
// Self-checking bench for scan_count_gen: directed scenarios plus a closed
// loop against a behavioural stand-in for fsm, with an address scoreboard.
module tb_scan_count_gen;
  import scan_pkg::*;

  localparam int AW = DW + LW + WW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    state = S0;
  logic          ready = 1'b0;
  logic [DW-1:0] count_data;
  logic [LW-1:0] count_line;
  logic [WW-1:0] count_wind;
  logic [AW-1:0] addr;
  logic          valid;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];

  scan_count_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .state      (state),
    .ready      (ready),
    .count_data (count_data),
    .count_line (count_line),
    .count_wind (count_wind),
    .addr       (addr),
    .valid      (valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; state = S0; ready = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({count_data, count_line, count_wind, addr, valid, busy, done, err} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got addr=%0h valid=%b busy=%b done=%b err=%b, expected all 0",
               addr, valid, busy, done, err);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (addr !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL idle_hold[%0d]: got addr=%0h valid=%b busy=%b, expected 0 0 0",
                 i, addr, valid, busy);
      end
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] exp;
    start = 1'b1; state = S0; ready = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b1 || count_data !== '0) begin
      failures++;
      $display("[TB] FAIL start_latency: got busy=%b valid=%b data=%0d, expected 1 1 0",
               busy, valid, count_data);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(AW'(i));
    ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (valid !== 1'b1 || addr !== exp) begin
        failures++;
        $display("[TB] FAIL stream_addr[%0d]: got valid=%b addr=%0h, expected 1 %0h",
                 i, valid, addr, exp);
      end
      step();
    end
    ready = 1'b0;
    #1;
    checks++;
    if (count_data !== 6'd5 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL stream_count: got data=%0d pending=%0d, expected 5 0",
               count_data, exp_q.size());
    end
  endtask

  task automatic test_stall();
    state = S0; ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || addr !== AW'(5)) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d]: got valid=%b addr=%0h, expected 1 5", i, valid, addr);
      end
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    #1;
    checks++;
    if (count_data !== 6'd6) begin
      failures++;
      $display("[TB] FAIL stall_release: got data=%0d, expected 6", count_data);
    end
    step();
    checks++;
    if (count_data !== 6'd6) begin
      failures++;
      $display("[TB] FAIL stall_single_step: got data=%0d, expected 6", count_data);
    end
  endtask

  task automatic test_phases();
    state = S1; ready = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL s1_valid: got %b, expected 0", valid);
    end
    step();
    step();
    checks++;
    if (count_line !== 4'd2 || count_wind !== 2'd0 || count_data !== 6'd6) begin
      failures++;
      $display("[TB] FAIL s1_counts: got line=%0d wind=%0d data=%0d, expected 2 0 6",
               count_line, count_wind, count_data);
    end
    state = S2;
    step();
    checks++;
    if (count_wind !== 2'd1 || count_line !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL s2_counts: got wind=%0d line=%0d busy=%b done=%b, expected 1 0 1 0",
               count_wind, count_line, busy, done);
    end
    state = S1;
    step();
    checks++;
    if (count_wind !== 2'd0 || count_line !== 4'd1) begin
      failures++;
      $display("[TB] FAIL s1_clears_wind: got wind=%0d line=%0d, expected 0 1", count_wind, count_line);
    end
    state = S0; ready = 1'b0;
    #1;
  endtask

  task automatic test_err();
    logic [AW-1:0] frozen;
    frozen = {2'd0, 4'd1, 6'd6};
    state = S_ILL; ready = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ill_valid: got %b, expected 0", valid);
    end
    step();
    checks++;
    if (err !== 1'b1 || addr !== frozen) begin
      failures++;
      $display("[TB] FAIL ill_freeze: got err=%b addr=%0h, expected 1 %0h", err, addr, frozen);
    end
    state = S0; ready = 1'b0;
    step();
    step();
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL err_sticky: got err=%b busy=%b, expected 1 1", err, busy);
    end
  endtask

  task automatic test_mid_reset();
    state = S0; ready = 1'b1;
    repeat (11) step();
    checks++;
    if (count_data !== 6'd17) begin
      failures++;
      $display("[TB] FAIL pre_reset_data: got %0d, expected 17", count_data);
    end
    reset = 1'b0; ready = 1'b0;
    step();
    checks++;
    if ({count_data, count_line, count_wind} !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset: got addr=%0h busy=%b done=%b err=%b, expected 0 0 0 0",
               addr, busy, done, err);
    end
    reset = 1'b1;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset: got done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_closed_loop();
    phase_e        ph;
    int            dcnt, wins;
    bit            ended;
    logic [AW-1:0] exp;
    for (int w = 0; w < 4; w++)
      for (int d = 0; d < 64; d++)
        exp_q.push_back(AW'((w << (DW + LW)) | d));
    start = 1'b1; state = S0; ready = 1'b0;
    step();
    start = 1'b0;
    ph = S0; dcnt = 0; wins = 0; ended = 1'b0;
    for (int cyc = 0; cyc < 5000 && !ended; cyc++) begin
      state = ph;
      ready = (ph == S0) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      start = (ph == S2 && wins == 3);
      #1;
      if (ph == S0 && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL loop_extra_transfer: got addr=%0h, expected none", addr);
        end else begin
          exp = exp_q.pop_front();
          if (valid !== 1'b1 || addr !== exp) begin
            failures++;
            $display("[TB] FAIL loop_addr: got valid=%b addr=%0h, expected 1 %0h", valid, addr, exp);
          end
        end
        dcnt++;
      end
      if (ph == S2) wins++;
      step();
      start = 1'b0;
      if (done) begin
        ended = 1'b1;
        checks++;
        if (busy !== 1'b0 || count_wind !== 2'd0 || wins != 4) begin
          failures++;
          $display("[TB] FAIL loop_done: got busy=%b wind=%0d windows=%0d, expected 0 0 4",
                   busy, count_wind, wins);
        end
      end
      if (ph == S0 && dcnt == 64) begin
        ph = S2;
        dcnt = 0;
      end else if (ph == S2) begin
        ph = S0;
      end
    end
    checks++;
    if (!ended) begin
      failures++;
      $display("[TB] FAIL loop_timeout: got no done, expected done after 4 windows");
    end
    state = S0; ready = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL loop_after: got done=%b busy=%b pending=%0d, expected 0 0 0",
               done, busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_phases();
    test_err();
    test_mid_reset();
    test_closed_loop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
